// File: rtl/car_motion_ctl.sv
// Car motion controller: integrates a signed speed into x/y position once per
// frame tick, with saturating throttle, friction, steering, clamping and crash lockout.
module car_motion_ctl #(
    parameter int POS_W        = 11,
    parameter int SPD_W        = 8,
    parameter int SPEED_MAX    = 16,
    parameter int ACCEL        = 2,
    parameter int FRICTION     = 1,
    parameter int STEER        = 3,
    parameter int X_MAX        = 1023,
    parameter int Y_MAX        = 767,
    parameter int X_START      = 0,
    parameter int Y_START      = 384,
    parameter int CRASH_FRAMES = 60
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic [3:0]       key,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic [SPD_W-1:0] speed,
    output logic             crashed
);

    localparam int SW    = SPD_W + 2;
    localparam int XW    = POS_W + 2;
    localparam int CNT_W = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;

    localparam logic signed [SW-1:0] SMAX_S = SW'(SPEED_MAX);
    localparam logic signed [SW-1:0] ACC_S  = SW'(ACCEL);
    localparam logic signed [SW-1:0] FRC_S  = SW'(FRICTION);
    localparam logic signed [XW-1:0] XMAX_S = XW'(X_MAX);
    localparam logic signed [XW-1:0] YMAX_S = XW'(Y_MAX);
    localparam logic signed [XW-1:0] STP_S  = XW'(STEER);

    typedef enum logic [1:0] {IDLE, RUN, CRASH} state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   xpos_q, xpos_d;
    logic [POS_W-1:0]   ypos_q, ypos_d;
    logic [SPD_W-1:0]   speed_q, speed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic signed [SW-1:0] spd_cur, spd_n;
    logic signed [XW-1:0] xn, yn;
    logic                 step;

    // Throttle/brake saturate at +/-SPEED_MAX; coasting decays toward 0 without crossing it.
    function automatic logic signed [SW-1:0] next_speed(
        input logic signed [SW-1:0] s,
        input logic                 up,
        input logic                 dn
    );
        logic signed [SW-1:0] r;
        if (up && !dn) begin
            r = s + ACC_S;
            if (r > SMAX_S) r = SMAX_S;
        end else if (dn && !up) begin
            r = s - ACC_S;
            if (r < -SMAX_S) r = -SMAX_S;
        end else if (s > FRC_S) begin
            r = s - FRC_S;
        end else if (s < -FRC_S) begin
            r = s + FRC_S;
        end else begin
            r = '0;
        end
        return r;
    endfunction

    function automatic logic [POS_W-1:0] clamp_pos(
        input logic signed [XW-1:0] v,
        input logic signed [XW-1:0] hi
    );
        logic [POS_W-1:0] r;
        if (v < 0)       r = '0;
        else if (v > hi) r = hi[POS_W-1:0];
        else             r = v[POS_W-1:0];
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        speed_d = speed_q;
        cnt_d   = cnt_q;

        spd_cur = $signed({{2{speed_q[SPD_W-1]}}, speed_q});
        spd_n   = next_speed(spd_cur, key[0], key[1]);
        xn      = $signed({2'b00, xpos_q}) + XW'(spd_n);
        if (key[2] && !key[3])      yn = $signed({2'b00, ypos_q}) - STP_S;
        else if (key[3] && !key[2]) yn = $signed({2'b00, ypos_q}) + STP_S;
        else                        yn = $signed({2'b00, ypos_q});

        step = frame_tick && (state_q == RUN || (state_q == IDLE && key != 4'd0));

        if (state_q == CRASH) begin
            if (frame_tick) begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
        end else if (step) begin
            state_d = RUN;
            xpos_d  = clamp_pos(xn, XMAX_S);
            if (xn < 0 || xn > XMAX_S) begin
                // Hitting a side wall stops the car dead; no steering on that frame.
                speed_d = '0;
                state_d = CRASH;
                cnt_d   = CNT_W'(CRASH_FRAMES - 1);
            end else begin
                speed_d = spd_n[SPD_W-1:0];
                if (spd_n != '0) ypos_d = clamp_pos(yn, YMAX_S);
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            xpos_q  <= POS_W'(X_START);
            ypos_q  <= POS_W'(Y_START);
            speed_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
        end
    end

    assign xpos    = xpos_q;
    assign ypos    = ypos_q;
    assign speed   = speed_q;
    assign crashed = (state_q == CRASH);

endmodule

// File: tb/tb_car_motion_ctl.sv
// Directed bench for car_motion_ctl: a vector table for the main motion path plus
// hand sequences for friction, y/x clamping, crash lockout and asynchronous reset.
module tb_car_motion_ctl;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        tick1 = 1'b0, tick2 = 1'b0;
    logic [3:0]  key1 = 4'd0, key2 = 4'd0;
    logic [10:0] xpos1, ypos1, xpos2, ypos2;
    logic [7:0]  speed1, speed2;
    logic        crashed1, crashed2;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    car_motion_ctl dut1 (
        .pclk(pclk), .rst(rst), .frame_tick(tick1), .key(key1),
        .xpos(xpos1), .ypos(ypos1), .speed(speed1), .crashed(crashed1)
    );

    car_motion_ctl #(.X_START(1003), .Y_START(2), .CRASH_FRAMES(3)) dut2 (
        .pclk(pclk), .rst(rst), .frame_tick(tick2), .key(key2),
        .xpos(xpos2), .ypos(ypos2), .speed(speed2), .crashed(crashed2)
    );

    typedef struct {
        logic [3:0] key;
        bit         tick;
        int         x;
        int         y;
        int         s;
        int         c;
    } vec_t;

    vec_t vt1[16];
    vec_t vt2[9];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic chk1(input string nm, input int x, input int y, input int s, input int c);
        chk({nm, ".x"}, int'(xpos1), x);
        chk({nm, ".y"}, int'(ypos1), y);
        chk({nm, ".spd"}, int'($signed(speed1)), s);
        chk({nm, ".crash"}, int'(crashed1), c);
    endtask

    task automatic chk2(input string nm, input int x, input int y, input int s, input int c);
        chk({nm, ".x"}, int'(xpos2), x);
        chk({nm, ".y"}, int'(ypos2), y);
        chk({nm, ".spd"}, int'($signed(speed2)), s);
        chk({nm, ".crash"}, int'(crashed2), c);
    endtask

    task automatic drive1(input logic [3:0] k, input bit t);
        @(negedge pclk);
        key1  = k;
        tick1 = t;
        @(negedge pclk);
        tick1 = 1'b0;
    endtask

    task automatic drive2(input logic [3:0] k, input bit t);
        @(negedge pclk);
        key2  = k;
        tick2 = t;
        @(negedge pclk);
        tick2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
    endtask

    initial begin
        int ex;
        //          key      tick  x    y    s   c
        vt1[0]  = '{4'b0001, 1'b1, 2,   384, 2,  0};
        vt1[1]  = '{4'b0001, 1'b1, 6,   384, 4,  0};
        vt1[2]  = '{4'b0001, 1'b1, 12,  384, 6,  0};
        vt1[3]  = '{4'b0001, 1'b1, 20,  384, 8,  0};
        vt1[4]  = '{4'b0001, 1'b1, 30,  384, 10, 0};
        vt1[5]  = '{4'b0001, 1'b1, 42,  384, 12, 0};
        vt1[6]  = '{4'b0001, 1'b1, 56,  384, 14, 0};
        vt1[7]  = '{4'b0001, 1'b1, 72,  384, 16, 0};
        vt1[8]  = '{4'b0001, 1'b1, 88,  384, 16, 0};
        vt1[9]  = '{4'b0011, 1'b1, 103, 384, 15, 0};
        vt1[10] = '{4'b0001, 1'b0, 103, 384, 15, 0};
        vt1[11] = '{4'b1001, 1'b1, 119, 387, 16, 0};
        vt1[12] = '{4'b0101, 1'b1, 135, 384, 16, 0};
        vt1[13] = '{4'b1100, 1'b1, 150, 384, 15, 0};
        vt1[14] = '{4'b0010, 1'b1, 163, 384, 13, 0};
        vt1[15] = '{4'b0010, 1'b1, 174, 384, 11, 0};

        // Second instance: X_START=1003, Y_START=2, CRASH_FRAMES=3.
        vt2[0]  = '{4'b0101, 1'b1, 1005, 0, 2,  0};
        vt2[1]  = '{4'b0101, 1'b1, 1009, 0, 4,  0};
        vt2[2]  = '{4'b0001, 1'b1, 1015, 0, 6,  0};
        vt2[3]  = '{4'b0001, 1'b1, 1023, 0, 8,  0};
        vt2[4]  = '{4'b0000, 1'b1, 1023, 0, 0,  1};
        vt2[5]  = '{4'b0001, 1'b1, 1023, 0, 0,  1};
        vt2[6]  = '{4'b0001, 1'b1, 1023, 0, 0,  1};
        vt2[7]  = '{4'b0001, 1'b1, 1023, 0, 0,  0};
        vt2[8]  = '{4'b0010, 1'b1, 1021, 0, -2, 0};

        repeat (2) @(negedge pclk);
        chk1("reset1", 0, 384, 0, 0);
        chk2("reset2", 1003, 2, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive1(vt1[i].key, vt1[i].tick);
            chk1($sformatf("vec%0d", i), vt1[i].x, vt1[i].y, vt1[i].s, vt1[i].c);
        end

        // Coast to a stop: speed falls by one each frame and never goes negative.
        ex = 174;
        for (int s = 10; s >= 0; s--) begin
            ex += s;
            drive1(4'b0000, 1'b1);
            chk1($sformatf("coast%0d", s), ex, 384, s, 0);
        end
        for (int i = 0; i < 2; i++) begin
            drive1(4'b0000, 1'b1);
            chk1("stopped", ex, 384, 0, 0);
        end
        drive1(4'b0100, 1'b1);
        chk1("steer_at_rest", ex, 384, 0, 0);

        for (int i = 0; i < 9; i++) begin
            drive2(vt2[i].key, vt2[i].tick);
            chk2($sformatf("edge%0d", i), vt2[i].x, vt2[i].y, vt2[i].s, vt2[i].c);
        end

        // Left-wall crash and full lockout length.
        do_reset();
        drive1(4'b0010, 1'b1);
        chk1("crash_entry", 0, 384, 0, 1);
        for (int i = 1; i < 60; i++) begin
            drive1(4'b0101, 1'b1);
            chk(  $sformatf("lock%0d.crash", i), int'(crashed1), 1);
            chk(  $sformatf("lock%0d.x", i), int'(xpos1), 0);
        end
        drive1(4'b0101, 1'b1);
        chk1("lock_exit", 0, 384, 0, 0);
        drive1(4'b0001, 1'b1);
        chk1("post_crash_run", 2, 384, 2, 0);

        // Asynchronous reset in the middle of a lockout.
        do_reset();
        drive1(4'b0010, 1'b1);
        chk1("crash2_entry", 0, 384, 0, 1);
        for (int i = 0; i < 30; i++) drive1(4'b0001, 1'b1);
        chk1("crash2_mid", 0, 384, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst", 0, 384, 0, 0);
        @(negedge pclk);
        rst = 1'b0;
        drive1(4'b0001, 1'b1);
        chk1("after_rst_run", 2, 384, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
